serial_add_sequencer: RTL and testbench



---
 rtl/serial_add_sequencer.sv | 145 ++++++++++++++
 tb/tb_serial_add_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial LSB-first add sequencer over two half-adder cells and a carry flop
// Optional subtract path enabled by defining SERIAL_ADD_SEQ_SUB_EN.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef SERIAL_ADD_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             busy_q, busy_d;

    logic             ha0_s, ha0_c, ha1_s, ha1_c;
    logic [WIDTH-1:0] sum_cat;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    always_comb begin
        ha0_s = a_sh_q[0] ^ b_sh_q[0];
        ha0_c = a_sh_q[0] & b_sh_q[0];
        ha1_s = ha0_s ^ carry_q;
        ha1_c = ha0_s & carry_q;
        // The last sum bit goes straight into out_sum, so the shifter keeps only WIDTH-1 bits.
        sum_cat = {ha1_s, sum_sh_q};
`ifdef SERIAL_ADD_SEQ_SUB_EN
        b_load = in_sub ? ~in_b : in_b;
        c_load = in_sub | in_cin;
`else
        b_load = in_b;
        c_load = in_cin;
`endif
    end

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        sum_sh_d   = sum_sh_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        case (state_q)
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d  = in_a;
                    b_sh_d  = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_cat[WIDTH-1:1];
                carry_d  = ha0_c | ha1_c;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    out_sum_d  = sum_cat;
                    out_cout_d = ha0_c | ha1_c;
                    cnt_d      = '0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_RUN) || (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_INIT;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - directed and streaming checks of serial_add_sequencer at WIDTH 8, 2 and 32
module tb_serial_add_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic v8, r8, c8, ov8, or8, co8, bz8, sub8;
    logic [7:0] a8, b8, s8;
    logic v2, r2, c2, ov2, or2, co2, bz2, sub2;
    logic [1:0] a2, b2, s2;
    logic v32, r32, c32, ov32, or32, co32, bz32, sub32;
    logic [31:0] a32, b32, s32;

    int errors = 0;
    int checks = 0;

    serial_add_sequencer #(.WIDTH(8)) u8 (
        .clk(clk), .reset_n(reset_n),
`ifdef SERIAL_ADD_SEQ_SUB_EN
        .in_sub(sub8),
`endif
        .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8), .in_cin(c8),
        .out_valid(ov8), .out_ready(or8), .out_sum(s8), .out_cout(co8), .busy(bz8));

    serial_add_sequencer #(.WIDTH(2)) u2 (
        .clk(clk), .reset_n(reset_n),
`ifdef SERIAL_ADD_SEQ_SUB_EN
        .in_sub(sub2),
`endif
        .in_valid(v2), .in_ready(r2), .in_a(a2), .in_b(b2), .in_cin(c2),
        .out_valid(ov2), .out_ready(or2), .out_sum(s2), .out_cout(co2), .busy(bz2));

    serial_add_sequencer #(.WIDTH(32)) u32 (
        .clk(clk), .reset_n(reset_n),
`ifdef SERIAL_ADD_SEQ_SUB_EN
        .in_sub(sub32),
`endif
        .in_valid(v32), .in_ready(r32), .in_a(a32), .in_b(b32), .in_cin(c32),
        .out_valid(ov32), .out_ready(or32), .out_sum(s32), .out_cout(co32), .busy(bz32));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {cout, sum} of A + B + cin (or A - B) reduced to w bits, by plain integer arithmetic.
    function automatic logic [32:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        longint unsigned mask, bb, t;
        mask = (64'd1 << w) - 64'd1;
        bb   = sub ? (~{32'd0, b} & mask) : {32'd0, b};
        t    = {32'd0, a} + bb + ((sub | cin) ? 64'd1 : 64'd0);
        t    = t & ((64'd1 << (w + 1)) - 64'd1);
        return t[32:0];
    endfunction

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, input logic [7:0] exp_sum, input logic exp_cout, input bit release_out);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (r8 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " in_ready"}, r8, 1);
        v8 = 1'b1; a8 = a; b8 = b; c8 = cin; sub8 = sub;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, lat, 8);
        chk({tag, " sum"}, s8, exp_sum);
        chk({tag, " cout"}, co8, exp_cout);
        chk({tag, " busy"}, bz8, 1);
        chk({tag, " ready_in_done"}, r8, 0);
        if (release_out) begin
            or8 = 1'b1;
            @(posedge clk);
            #1;
            or8 = 1'b0;
            chk({tag, " valid_drop"}, ov8, 0);
            chk({tag, " back_idle"}, r8, 1);
        end
    endtask

    logic [32:0] q8[$], q2[$], q32[$];
    logic [32:0] e;
    int last8, last2, last32, n8, n2, n32;

    initial begin
        reset_n = 1'b0;
        {v8, c8, or8, sub8, v2, c2, or2, sub2, v32, c32, or32, sub32} = '0;
        a8 = '0; b8 = '0; a2 = '0; b2 = '0; a32 = '0; b32 = '0;

        #12;
        chk("rst in_ready", r8, 0);
        chk("rst out_valid", ov8, 0);
        chk("rst out_sum", s8, 0);
        chk("rst out_cout", co8, 0);
        chk("rst busy", bz8, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("init in_ready", r8, 0);
        @(posedge clk);
        #1;
        chk("idle in_ready", r8, 1);
        chk("idle busy", bz8, 0);

        op8("add5a33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
        op8("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        op8("addffff1", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
        op8("add000", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
`ifdef SERIAL_ADD_SEQ_SUB_EN
        op8("sub1001", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b1);
        op8("sub0102", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
`endif

        op8("bp", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
        v8 = 1'b1; a8 = 8'hAA; b8 = 8'hCC; c8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp valid", ov8, 1);
            chk("bp sum", s8, 8'h47);
            chk("bp ready", r8, 0);
        end
        or8 = 1'b1; v8 = 1'b0;
        @(posedge clk);
        #1;
        or8 = 1'b0;
        chk("bp release valid", ov8, 0);
        chk("bp release ready", r8, 1);
        chk("bp release busy", bz8, 0);
        chk("bp idle hold sum", s8, 8'h47);
        @(posedge clk);
        #1;
        chk("bp not captured", bz8, 0);

        @(negedge clk);
        v8 = 1'b1; a8 = 8'h5A; b8 = 8'h33; c8 = 1'b0;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrun rst valid", ov8, 0);
        chk("midrun rst sum", s8, 0);
        chk("midrun rst busy", bz8, 0);
        chk("midrun rst ready", r8, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("midrun init ready", r8, 0);
        @(posedge clk);
        #1;
        chk("midrun idle ready", r8, 1);
        chk("midrun no result", ov8, 0);

        last8 = -1; last2 = -1; last32 = -1;
        n8 = 0; n2 = 0; n32 = 0;
        v8 = 1'b1; or8 = 1'b1; v2 = 1'b1; or2 = 1'b1; v32 = 1'b1; or32 = 1'b1;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            if (ov8 === 1'b1) begin
                e = (q8.size() > 0) ? q8.pop_front() : 33'h1_FFFF_FFFF;
                chk("stream8 result", {co8, s8}, e);
                if (last8 >= 0) chk("stream8 interval", cyc - last8, 10);
                last8 = cyc; n8++;
            end
            if (ov2 === 1'b1) begin
                e = (q2.size() > 0) ? q2.pop_front() : 33'h1_FFFF_FFFF;
                chk("stream2 result", {co2, s2}, e);
                if (last2 >= 0) chk("stream2 interval", cyc - last2, 4);
                last2 = cyc; n2++;
            end
            if (ov32 === 1'b1) begin
                e = (q32.size() > 0) ? q32.pop_front() : 33'h1_FFFF_FFFF;
                chk("stream32 result", {co32, s32}, e);
                if (last32 >= 0) chk("stream32 interval", cyc - last32, 34);
                last32 = cyc; n32++;
            end
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1));
            a2 = 2'($urandom); b2 = 2'($urandom); c2 = 1'($urandom_range(0, 1));
            a32 = $urandom; b32 = $urandom; c32 = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SEQ_SUB_EN
            sub8 = 1'($urandom_range(0, 1)); sub2 = 1'($urandom_range(0, 1));
            sub32 = 1'($urandom_range(0, 1));
`endif
            if (r8 === 1'b1) q8.push_back(ref_add(8, {24'd0, a8}, {24'd0, b8}, c8, sub8));
            if (r2 === 1'b1) q2.push_back(ref_add(2, {30'd0, a2}, {30'd0, b2}, c2, sub2));
            if (r32 === 1'b1) q32.push_back(ref_add(32, a32, b32, c32, sub32));
        end
        chk("stream8 count", n8 >= 60, 1);
        chk("stream2 count", n2 >= 150, 1);
        chk("stream32 count", n32 >= 18, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
